// File: rtl/dct_pkg.sv
// dct_pkg: shared widths and coefficients for the DCT frame loader and transform.
package dct_pkg;
    localparam int SAMPLE_W  = 4;
    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int OUT_W     = 12;
    localparam int C1        = 1;
    localparam int C2        = 2;
    localparam int C3        = 3;
endpackage

// File: rtl/dct_frame_buf.sv
// dct_frame_buf: one 4-entry sample register bank, indexed write, parallel read.
module dct_frame_buf
    import dct_pkg::*;
#(
    parameter int W = SAMPLE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_q0,
    output logic [W-1:0]     o_q1,
    output logic [W-1:0]     o_q2,
    output logic [W-1:0]     o_q3
);
    logic [W-1:0] r_mem [FRAME_LEN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_LEN; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_idx] <= i_data;
        end
    end

    assign o_q0 = r_mem[0];
    assign o_q1 = r_mem[1];
    assign o_q2 = r_mem[2];
    assign o_q3 = r_mem[3];
endmodule

// File: rtl/dct_frame_loader.sv
// dct_frame_loader: packs a serial sample stream into 4-sample frames,
// ping-pong buffered so intake continues while the DCT stage holds a frame.
module dct_frame_loader
    import dct_pkg::*;
#(
    parameter int SAMPLE_W = dct_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_sof,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SAMPLE_W-1:0] x0,
    output logic [SAMPLE_W-1:0] x1,
    output logic [SAMPLE_W-1:0] x2,
    output logic [SAMPLE_W-1:0] x3,
    output logic                sof_err
);
    logic [IDX_W-1:0]    r_idx;
    logic                r_wr_sel;
    logic                r_rd_sel;
    logic [1:0]          r_full;
    logic                w_acc;
    logic                w_xfer;
    logic                w_done;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [1:0]          w_full_nxt;
    logic                w_rd_nxt;
    logic                w_we_a;
    logic                w_we_b;
    logic [SAMPLE_W-1:0] w_qa [FRAME_LEN];
    logic [SAMPLE_W-1:0] w_qb [FRAME_LEN];
    logic [SAMPLE_W-1:0] w_na [FRAME_LEN];
    logic [SAMPLE_W-1:0] w_nb [FRAME_LEN];

    assign w_acc      = s_valid && s_ready;
    assign w_xfer     = m_valid && m_ready;
    assign w_wr_idx   = s_sof ? '0 : r_idx;
    assign w_done     = w_acc && (w_wr_idx == IDX_W'(FRAME_LEN - 1));
    assign w_idx_nxt  = !w_acc ? r_idx : w_done ? '0 : w_wr_idx + 1'b1;
    assign w_full_nxt = r_full + {1'b0, w_done} - {1'b0, w_xfer};
    assign w_rd_nxt   = r_rd_sel ^ w_xfer;
    assign w_we_a     = w_acc && !r_wr_sel;
    assign w_we_b     = w_acc && r_wr_sel;

    dct_frame_buf #(.W(SAMPLE_W)) u_buf_a (
        .clk(clk), .rst_n(rst_n), .i_we(w_we_a), .i_idx(w_wr_idx), .i_data(s_data),
        .o_q0(w_qa[0]), .o_q1(w_qa[1]), .o_q2(w_qa[2]), .o_q3(w_qa[3])
    );

    dct_frame_buf #(.W(SAMPLE_W)) u_buf_b (
        .clk(clk), .rst_n(rst_n), .i_we(w_we_b), .i_idx(w_wr_idx), .i_data(s_data),
        .o_q0(w_qb[0]), .o_q1(w_qb[1]), .o_q2(w_qb[2]), .o_q3(w_qb[3])
    );

    // Post-write view of both banks so a frame completing this cycle is presented next cycle.
    always_comb begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            w_na[i] = (w_we_a && w_wr_idx == IDX_W'(i)) ? s_data : w_qa[i];
            w_nb[i] = (w_we_b && w_wr_idx == IDX_W'(i)) ? s_data : w_qb[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_full   <= '0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            sof_err  <= 1'b0;
            x0       <= '0;
            x1       <= '0;
            x2       <= '0;
            x3       <= '0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_wr_sel <= r_wr_sel ^ w_done;
            r_rd_sel <= w_rd_nxt;
            r_full   <= w_full_nxt;
            s_ready  <= w_full_nxt < 2'd2;
            m_valid  <= w_full_nxt != 2'd0;
            sof_err  <= w_acc && s_sof && (r_idx != '0);
            x0       <= w_rd_nxt ? w_nb[0] : w_na[0];
            x1       <= w_rd_nxt ? w_nb[1] : w_na[1];
            x2       <= w_rd_nxt ? w_nb[2] : w_na[2];
            x3       <= w_rd_nxt ? w_nb[3] : w_na[3];
        end
    end
endmodule

// File: tb/tb_dct_frame_loader.sv
// tb_dct_frame_loader: directed vectors for the DCT frame loader.
module tb_dct_frame_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_data;
    logic       s_sof;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] x0, x1, x2, x3;
    logic       sof_err;
    int         n_chk = 0;
    int         n_err = 0;

    dct_frame_loader dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic sof);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        step();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] exp);
        chk({tag, " m_valid"}, m_valid, 1);
        chk({tag, " x"}, {x0, x1, x2, x3}, exp);
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; m_ready = 1'b0;
        step(); step();
        chk("rst s_ready", s_ready, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst sof_err", sof_err, 0);
        chk("rst x", {x0, x1, x2, x3}, 0);
        rst_n = 1'b1;
        step();
        chk("ready after rst", s_ready, 1);

        // basic frame
        m_ready = 1'b1;
        send(4'h1, 0); send(4'hE, 0); send(4'h3, 0); send(4'hC, 0);
        chk_frame("basic", 16'h1E3C);
        step();
        chk("basic drop", m_valid, 0);
        chk("basic ready", s_ready, 1);

        // backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(4'(i), 0);
        chk("bp ready low", s_ready, 0);
        chk_frame("bp f0", 16'h0123);
        s_valid = 1'b1; s_data = 4'h8;
        step();
        chk("bp held ready", s_ready, 0);
        chk_frame("bp f0 stable", 16'h0123);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk_frame("bp f1", 16'h4567);
        chk("bp ready back", s_ready, 1);
        step();
        s_valid = 1'b0;
        chk_frame("bp f1 stable", 16'h4567);
        chk("bp ready after -8", s_ready, 1);
        m_ready = 1'b1;
        step();
        chk("bp drain", m_valid, 0);

        // realign: partial frame (-8,5,6) dropped by s_sof on 7
        send(4'h5, 0);
        chk("sof 5", sof_err, 0);
        send(4'h6, 0);
        chk("sof 6", sof_err, 0);
        chk("sof no frame", m_valid, 0);
        send(4'h7, 1);
        chk("sof pulse", sof_err, 1);
        send(4'h1, 0);
        chk("sof pulse end", sof_err, 0);
        send(4'h2, 0);
        send(4'h3, 0);
        chk_frame("sof frame", 16'h7123);
        step();
        chk("sof drop", m_valid, 0);

        // streaming with simultaneous completion and transfer
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 4'(i);
            step();
            chk("stream ready", s_ready, 1);
            if (i % 4 == 3) chk_frame("stream", {4'(i - 3), 4'(i - 2), 4'(i - 1), 4'(i)});
            else chk("stream idle", m_valid, 0);
        end
        s_valid = 1'b0;
        step();
        chk("stream drain", m_valid, 0);

        // reset mid-frame
        send(4'h1, 0); send(4'h2, 0);
        rst_n = 1'b0; s_valid = 1'b1; s_data = 4'h3;
        step();
        chk("mid rst ready", s_ready, 0);
        chk("mid rst m_valid", m_valid, 0);
        chk("mid rst x", {x0, x1, x2, x3}, 0);
        rst_n = 1'b1;
        step();
        s_valid = 1'b0;
        chk("post rst ready", s_ready, 1);
        chk("post rst m_valid", m_valid, 0);
        chk("post rst sof_err", sof_err, 0);
        send(4'h7, 0); send(4'h8, 0); send(4'h7, 0);
        chk("post rst partial", m_valid, 0);
        send(4'h8, 0);
        chk_frame("post rst", 16'h7878);
        step();

        // extremes
        send(4'h8, 0); send(4'h8, 0); send(4'h7, 0);
        chk("ext sof_err", sof_err, 0);
        send(4'h7, 0);
        chk_frame("ext", 16'h8877);
        chk("ext sof_err end", sof_err, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
